// File: rtl/tnn_neuron_seq.sv
// tnn_neuron_seq: sequential threshold neuron.
// A captured vector of N_IN unsigned activations is folded one input per cycle
// into a positive or a negative sum (chosen by POS_MASK). The neuron then fires
// when the positive sum exceeds the negative sum plus THRESH.
// A single adder path is reused for every input, trading latency for area.
module tnn_neuron_seq #(
  parameter int unsigned       N_IN     = 5,
  parameter int unsigned       IN_W     = 2,
  parameter logic [N_IN-1:0]   POS_MASK = 5'b01010,
  parameter int unsigned       THRESH   = 0,
  localparam int unsigned      ACC_W    = IN_W + $clog2(N_IN + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N_IN*IN_W-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_bit,
  output logic [ACC_W-1:0]     out_pos,
  output logic [ACC_W-1:0]     out_neg
);

  localparam int unsigned        IDX_W    = $clog2(N_IN);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(N_IN - 1);
  // Bias is pre-extended by one bit so neg + THRESH can never wrap in the compare.
  localparam logic [ACC_W:0]     THRESH_X = {1'b0, ACC_W'(THRESH)};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    CMP   = 2'd2,
    OUT   = 2'd3
  } state_t;

  state_t                 state;
  logic [N_IN*IN_W-1:0]   shadow;
  logic [IDX_W-1:0]       idx;
  logic [ACC_W-1:0]       pos_acc;
  logic [ACC_W-1:0]       neg_acc;
  logic [IN_W-1:0]        cur_in;
  logic [ACC_W-1:0]       cur_ext;

  // Handshake flags are plain state decodes; everything else is registered.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == OUT);

  // Pick the input addressed by idx from the captured vector and zero-extend it.
  assign cur_in  = shadow[idx*IN_W +: IN_W];
  assign cur_ext = ACC_W'(cur_in);

  // Main FSM: capture, serial accumulate, compare, then hold the result until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      shadow  <= '0;
      idx     <= '0;
      pos_acc <= '0;
      neg_acc <= '0;
      out_bit <= 1'b0;
      out_pos <= '0;
      out_neg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            shadow  <= in_data;
            pos_acc <= '0;
            neg_acc <= '0;
            idx     <= '0;
            state   <= ACCUM;
          end
        end
        ACCUM: begin
          if (POS_MASK[idx]) begin
            pos_acc <= pos_acc + cur_ext;
          end else begin
            neg_acc <= neg_acc + cur_ext;
          end
          if (idx == LAST_IDX) begin
            idx   <= '0;
            state <= CMP;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        CMP: begin
          out_bit <= ({1'b0, pos_acc} > ({1'b0, neg_acc} + THRESH_X));
          out_pos <= pos_acc;
          out_neg <= neg_acc;
          state   <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tnn_neuron_seq.sv
// tb_tnn_neuron_seq: directed and randomized checks of tnn_neuron_seq.
// Three instances cover the default neuron, a wide all-positive neuron and a
// neuron with a non-zero threshold. Expected sums come from a simple loop model.
module tb_tnn_neuron_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iv   [3];
  logic        ordy [3];
  logic        ir   [3];
  logic        ov   [3];
  logic        ob   [3];
  logic [63:0] id   [3];
  logic [31:0] op   [3];
  logic [31:0] on   [3];

  logic [4:0] op0, on0;
  logic [7:0] op1, on1;
  logic [5:0] op2, on2;

  int n_in   [3] = '{5, 8, 4};
  int in_w   [3] = '{2, 4, 3};
  int mask_of[3] = '{32'b01010, 32'hFF, 32'b0011};
  int thr_of [3] = '{0, 0, 2};

  int n_vectors    = 0;
  int n_miscompares = 0;

  assign op[0] = 32'(op0);
  assign on[0] = 32'(on0);
  assign op[1] = 32'(op1);
  assign on[1] = 32'(on1);
  assign op[2] = 32'(op2);
  assign on[2] = 32'(on2);

  tnn_neuron_seq #(.N_IN(5), .IN_W(2), .POS_MASK(5'b01010), .THRESH(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
    .in_data(id[0][9:0]), .out_valid(ov[0]), .out_ready(ordy[0]),
    .out_bit(ob[0]), .out_pos(op0), .out_neg(on0));

  tnn_neuron_seq #(.N_IN(8), .IN_W(4), .POS_MASK(8'hFF), .THRESH(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
    .in_data(id[1][31:0]), .out_valid(ov[1]), .out_ready(ordy[1]),
    .out_bit(ob[1]), .out_pos(op1), .out_neg(on1));

  tnn_neuron_seq #(.N_IN(4), .IN_W(3), .POS_MASK(4'b0011), .THRESH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
    .in_data(id[2][11:0]), .out_valid(ov[2]), .out_ready(ordy[2]),
    .out_bit(ob[2]), .out_pos(op2), .out_neg(on2));

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  // Hard stop in case a sequence never completes.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] simulation watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vectors++;
    assert (got === exp) else begin
      n_miscompares++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Reference neuron: sum each input into the side its mask bit selects.
  function automatic void refModel(input int k, input logic [63:0] vec,
                                   output int pos, output int neg, output int fire);
    logic [63:0] field;
    pos = 0;
    neg = 0;
    for (int i = 0; i < n_in[k]; i++) begin
      field = (vec >> (i * in_w[k])) & ((64'd1 << in_w[k]) - 64'd1);
      if (((mask_of[k] >> i) & 1) == 1) pos += int'(field);
      else                              neg += int'(field);
    end
    fire = (pos > neg + thr_of[k]) ? 1 : 0;
  endfunction

  function automatic logic [63:0] pack5(input int a, input int b, input int c,
                                        input int d, input int e);
    return {54'd0, 2'(e), 2'(d), 2'(c), 2'(b), 2'(a)};
  endfunction

  function automatic logic [63:0] vecMask(input int k);
    return (64'd1 << (n_in[k] * in_w[k])) - 64'd1;
  endfunction

  // Present one vector, scramble in_data while busy, then check latency, result and hold.
  task automatic applyStimulus(input int k, input logic [63:0] vec, input int hold);
    int cycles;
    int busy_ready;
    int ep, en, eb;
    bit stable;
    refModel(k, vec, ep, en, eb);
    id[k] = vec;
    iv[k] = 1'b1;
    checkOutput($sformatf("in_ready_idle[%0d]", k), 32'(ir[k]), 32'd1);
    tick();
    iv[k] = 1'b0;
    cycles = 1;
    busy_ready = 0;
    while (!ov[k] && cycles < 40) begin
      if (ir[k]) busy_ready++;
      id[k] = {$urandom, $urandom};
      tick();
      cycles++;
    end
    checkOutput($sformatf("latency[%0d]", k), 32'(cycles), 32'(n_in[k] + 2));
    checkOutput($sformatf("busy_in_ready[%0d]", k), 32'(busy_ready), 32'd0);
    checkOutput($sformatf("out_pos[%0d]", k), op[k], 32'(ep));
    checkOutput($sformatf("out_neg[%0d]", k), on[k], 32'(en));
    checkOutput($sformatf("out_bit[%0d]", k), 32'(ob[k]), 32'(eb));
    if (hold > 0) begin
      ordy[k] = 1'b0;
      stable = 1'b1;
      repeat (hold) begin
        tick();
        if (!ov[k] || ir[k] || op[k] != 32'(ep) || on[k] != 32'(en) || ob[k] != eb[0])
          stable = 1'b0;
      end
      checkOutput($sformatf("hold_stable[%0d]", k), 32'(stable), 32'd1);
      ordy[k] = 1'b1;
    end
    tick();
    checkOutput($sformatf("valid_pulse[%0d]", k), 32'(ov[k]), 32'd0);
    checkOutput($sformatf("back_to_idle[%0d]", k), 32'(ir[k]), 32'd1);
  endtask

  // Directed sequence followed by randomized vectors on all three neurons.
  initial begin
    int cyc;
    int ep, en, eb;
    bit stable;
    int k;
    logic [63:0] vec;

    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      iv[i]   = 1'b0;
      ordy[i] = 1'b1;
      id[i]   = '0;
    end
    tick();
    tick();
    checkOutput("rst_in_ready", 32'(ir[0]), 32'd1);
    checkOutput("rst_out_valid", 32'(ov[0]), 32'd0);
    checkOutput("rst_out_bit", 32'(ob[0]), 32'd0);
    checkOutput("rst_out_pos", op[0], 32'd0);
    checkOutput("rst_out_neg", on[0], 32'd0);
    rst_n = 1'b1;
    tick();

    $display("[TB] basic vector a=3 b=2 c=0 d=2 e=0");
    applyStimulus(0, pack5(3, 2, 0, 2, 0), 0);

    $display("[TB] reset during accumulation");
    id[0] = pack5(0, 3, 0, 3, 0);
    iv[0] = 1'b1;
    tick();
    iv[0] = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_in_ready", 32'(ir[0]), 32'd1);
    checkOutput("midrst_out_valid", 32'(ov[0]), 32'd0);
    checkOutput("midrst_out_bit", 32'(ob[0]), 32'd0);
    checkOutput("midrst_out_pos", op[0], 32'd0);
    checkOutput("midrst_out_neg", on[0], 32'd0);
    #1;
    rst_n = 1'b1;
    applyStimulus(0, pack5(0, 3, 0, 3, 0), 0);

    $display("[TB] tie and near-tie");
    applyStimulus(0, pack5(1, 1, 0, 1, 1), 0);
    applyStimulus(0, pack5(0, 1, 0, 1, 1), 0);
    applyStimulus(0, pack5(3, 3, 3, 3, 3), 0);

    $display("[TB] wide all-positive neuron at full scale");
    applyStimulus(1, 64'hFFFF_FFFF, 0);

    $display("[TB] threshold boundary");
    applyStimulus(2, {52'd0, 3'd2, 3'd1, 3'd3, 3'd2}, 0);
    applyStimulus(2, {52'd0, 3'd2, 3'd1, 3'd3, 3'd3}, 0);

    $display("[TB] backpressure with in_valid held");
    id[0] = pack5(2, 3, 1, 1, 0);
    iv[0] = 1'b1;
    tick();
    id[0] = pack5(0, 2, 0, 3, 1);
    cyc = 1;
    while (!ov[0] && cyc < 40) begin
      tick();
      cyc++;
    end
    checkOutput("bp_latency", 32'(cyc), 32'd7);
    refModel(0, pack5(2, 3, 1, 1, 0), ep, en, eb);
    ordy[0] = 1'b0;
    stable = 1'b1;
    repeat (10) begin
      tick();
      if (!ov[0] || ir[0] || op[0] != 32'(ep) || on[0] != 32'(en) || ob[0] != eb[0])
        stable = 1'b0;
    end
    checkOutput("bp_stable", 32'(stable), 32'd1);
    ordy[0] = 1'b1;
    tick();
    checkOutput("bp_release_ready", 32'(ir[0]), 32'd1);
    checkOutput("bp_release_valid", 32'(ov[0]), 32'd0);
    tick();
    iv[0] = 1'b0;
    checkOutput("bp_accepted", 32'(ir[0]), 32'd0);
    cyc = 0;
    while (!ov[0] && cyc < 40) begin
      id[0] = 64'(($urandom));
      tick();
      cyc++;
    end
    checkOutput("bp_second_latency", 32'(cyc), 32'd6);
    refModel(0, pack5(0, 2, 0, 3, 1), ep, en, eb);
    checkOutput("bp_second_pos", op[0], 32'(ep));
    checkOutput("bp_second_neg", on[0], 32'(en));
    checkOutput("bp_second_bit", 32'(ob[0]), 32'(eb));
    tick();

    $display("[TB] randomized vectors");
    for (int r = 0; r < 12; r++) begin
      k = int'($urandom_range(0, 2));
      vec = {$urandom, $urandom} & vecMask(k);
      applyStimulus(k, vec, int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
